// File: rtl/mem_sequencer_if.sv
// CPU-side handshake and memory-manager bus of mem_sequencer.
// The fetch_count signal exists only when FETCH_COUNT_EN is defined.
interface mem_sequencer_if;
    // CPU core requests
    logic        fetch_req;
    logic        xfer_req;
    logic        xfer_write;
    logic [3:0]  xfer_last;
    logic [11:0] xfer_addr;
    logic        pc_load;
    logic [11:0] pc_value;
    logic        pc_skip;
    // Memory manager controls and CPU status
    logic [11:0] pc;
    logic [11:0] address;
    logic [3:0]  address_counter;
    logic        write_enable;
    logic [3:0]  write_count;
    logic        busy;
    logic        done;
    logic        opcode_valid;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    modport master (
        output fetch_req, xfer_req, xfer_write, xfer_last, xfer_addr,
        output pc_load, pc_value, pc_skip,
        input  pc, address, address_counter, write_enable, write_count,
        input  busy, done, opcode_valid
`ifdef FETCH_COUNT_EN
        , input fetch_count
`endif
    );

    modport slave (
        input  fetch_req, xfer_req, xfer_write, xfer_last, xfer_addr,
        input  pc_load, pc_value, pc_skip,
        output pc, address, address_counter, write_enable, write_count,
        output busy, done, opcode_valid
`ifdef FETCH_COUNT_EN
        , output fetch_count
`endif
    );
endinterface

// File: rtl/mem_sequencer.sv
// Opcode-fetch / block-transfer sequencer in front of the memory manager.
// Define FETCH_COUNT_EN to add the 16-bit completed-fetch counter (bus.fetch_count).
module mem_sequencer #(
    parameter logic [11:0] PC_RESET = 12'h200,
    parameter logic [11:0] PC_STEP  = 12'd2
) (
    input logic            clk,
    input logic            reset,
    mem_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchHi,
        StFetchLo,
        StXfer,
        StDone
    } state_e;

    state_e     state_q;
    logic [3:0] last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= StIdle;
            last_q              <= 4'd0;
            bus.pc              <= PC_RESET;
            bus.address         <= 12'd0;
            bus.address_counter <= 4'd0;
            bus.write_enable    <= 1'b0;
            bus.write_count     <= 4'd0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.opcode_valid    <= 1'b0;
`ifdef FETCH_COUNT_EN
            bus.fetch_count     <= 16'd0;
`endif
        end else begin
            bus.done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // Transfers win over fetches; neither is queued once busy.
                    if (bus.xfer_req) begin
                        bus.address         <= bus.xfer_addr;
                        last_q              <= bus.xfer_last;
                        bus.write_count     <= bus.xfer_write ? bus.xfer_last : 4'd0;
                        bus.write_enable    <= bus.xfer_write;
                        bus.address_counter <= 4'd0;
                        bus.busy            <= 1'b1;
                        bus.opcode_valid    <= 1'b0;
                        state_q             <= StXfer;
                    end else if (bus.fetch_req) begin
                        bus.address_counter <= 4'd0;
                        bus.busy            <= 1'b1;
                        bus.opcode_valid    <= 1'b0;
                        state_q             <= StFetchHi;
                    end
                end

                StFetchHi: begin
                    bus.address_counter <= 4'd1;
                    state_q             <= StFetchLo;
                end

                StFetchLo: begin
                    bus.address_counter <= 4'd0;
                    bus.opcode_valid    <= 1'b1;
                    bus.done            <= 1'b1;
                    state_q             <= StDone;
`ifdef FETCH_COUNT_EN
                    bus.fetch_count     <= bus.fetch_count + 16'd1;
`endif
                end

                StXfer: begin
                    if (bus.address_counter == last_q) begin
                        bus.write_enable    <= 1'b0;
                        bus.address_counter <= 4'd0;
                        bus.done            <= 1'b1;
                        state_q             <= StDone;
                    end else begin
                        bus.address_counter <= bus.address_counter + 4'd1;
                    end
                end

                StDone: begin
                    bus.busy <= 1'b0;
                    state_q  <= StIdle;
                end

                default: begin
                    bus.busy         <= 1'b0;
                    bus.write_enable <= 1'b0;
                    state_q          <= StIdle;
                end
            endcase

            // A load overrides the post-fetch increment; skip only applies while idle.
            if (bus.pc_load) begin
                bus.pc <= bus.pc_value;
            end else if (state_q == StFetchLo) begin
                bus.pc <= bus.pc + PC_STEP;
            end else if (state_q == StIdle && bus.pc_skip) begin
                bus.pc <= bus.pc + PC_STEP;
            end
        end
    end

endmodule
